// File: rtl/decompose_mul_share_arb_if.sv
// Requester/result handshake bundle for the shared-multiplier arbiter.
// The slave modport is the arbiter side; master is the requester/consumer side.
interface decompose_mul_share_arb_if #(
    parameter int NUM_REQ = 4,
    parameter int A_WIDTH = 31,
    parameter int B_WIDTH = 33,
    parameter int P_WIDTH = 44,
    parameter int ID_W    = 2
) ();
    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ*A_WIDTH-1:0] req_a;
    logic [NUM_REQ*B_WIDTH-1:0] req_b;
    logic [NUM_REQ-1:0]         req_ready;
    logic                       res_valid;
    logic [P_WIDTH-1:0]         res_data;
    logic [ID_W-1:0]            res_id;
    logic                       res_ready;

    modport slave (
        input  req_valid, req_a, req_b, res_ready,
        output req_ready, res_valid, res_data, res_id
    );

    modport master (
        output req_valid, req_a, req_b, res_ready,
        input  req_ready, res_valid, res_data, res_id
    );
endinterface

// File: rtl/decompose_mul_share_arb.sv
// Round-robin sequencer sharing one external pipelined multiplier among NUM_REQ requesters,
// carrying each product's requester tag alongside it and stalling the multiplier on backpressure.
module decompose_mul_share_arb #(
    parameter int NUM_REQ     = 4,
    parameter int A_WIDTH     = 31,
    parameter int B_WIDTH     = 33,
    parameter int P_WIDTH     = 44,
    parameter int MUL_LATENCY = 1,
    parameter int ID_W        = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     ce,
    decompose_mul_share_arb_if.slave bus,
    output logic [A_WIDTH-1:0]       mul_din0,
    output logic [B_WIDTH-1:0]       mul_din1,
    output logic                     mul_ce,
    input  logic [P_WIDTH-1:0]       mul_dout,
    output logic                     busy
);

    logic [MUL_LATENCY-1:0] vld_q;
    logic [ID_W-1:0]        tag_q [MUL_LATENCY];
    logic [ID_W-1:0]        ptr_q;
    logic [A_WIDTH-1:0]     hold_a_q;
    logic [B_WIDTH-1:0]     hold_b_q;

    logic                   advance;
    logic                   xfer;
    logic                   gnt_found;
    logic [ID_W-1:0]        gnt_idx;
    logic [ID_W:0]          cand;

    assign bus.res_valid = vld_q[MUL_LATENCY-1];
    assign bus.res_id    = tag_q[MUL_LATENCY-1];
    assign bus.res_data  = mul_dout;
    assign busy          = |vld_q;

    // The whole pipeline, multiplier included, moves only when the output slot can drain.
    assign advance = ce & ~reset & (~bus.res_valid | bus.res_ready);
    assign mul_ce  = advance;
    assign xfer    = gnt_found & advance;

    // NOTE: every variable driven here gets a default first so no latch is inferred.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, ptr_q} + (ID_W+1)'(k + 1);
            if (cand >= (ID_W+1)'(NUM_REQ)) begin
                cand = cand - (ID_W+1)'(NUM_REQ);
            end
            if (!gnt_found && bus.req_valid[cand[ID_W-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand[ID_W-1:0];
            end
        end
    end

    assign bus.req_ready = xfer ? (NUM_REQ'(1) << gnt_idx) : '0;

    // Idle operands park on the last issued pair so the multiplier inputs do not toggle.
    always_comb begin
        if (gnt_found) begin
            mul_din0 = bus.req_a[int'(gnt_idx)*A_WIDTH +: A_WIDTH];
            mul_din1 = bus.req_b[int'(gnt_idx)*B_WIDTH +: B_WIDTH];
        end else begin
            mul_din0 = hold_a_q;
            mul_din1 = hold_b_q;
        end
    end

    // NOTE: the operand hold registers carry no reset; they only feed multiplier lanes whose
    // valid bits are cleared, so their power-up contents never reach a result.
    always_ff @(posedge clk) begin
        if (xfer) begin
            hold_a_q <= mul_din0;
            hold_b_q <= mul_din1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every stage samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_q <= '0;
            for (int i = 0; i < MUL_LATENCY; i++) begin
                tag_q[i] <= '0;
            end
            ptr_q <= ID_W'(NUM_REQ - 1);
        end else if (advance) begin
            vld_q[0] <= xfer;
            tag_q[0] <= gnt_idx;
            for (int i = 1; i < MUL_LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
                tag_q[i] <= tag_q[i-1];
            end
            if (xfer) begin
                ptr_q <= gnt_idx;
            end
        end
    end

endmodule

// File: tb/tb_decompose_mul_share_arb.sv
// Self-checking bench for decompose_mul_share_arb: directed scenarios plus a randomized run
// scored against a queue-based model of the sequencer, with a behavioural multiplier attached.
module tb_decompose_mul_share_arb;

    localparam int NUM_REQ     = 4;
    localparam int A_WIDTH     = 31;
    localparam int B_WIDTH     = 33;
    localparam int P_WIDTH     = 44;
    localparam int MUL_LATENCY = 1;
    localparam int ID_W        = 2;

    logic clk = 1'b0;
    logic reset;
    logic ce;
    logic [A_WIDTH-1:0] mul_din0;
    logic [B_WIDTH-1:0] mul_din1;
    logic               mul_ce;
    logic [P_WIDTH-1:0] mul_dout;
    logic               busy;

    logic [A_WIDTH-1:0] a_r [NUM_REQ];
    logic [B_WIDTH-1:0] b_r [NUM_REQ];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    decompose_mul_share_arb_if #(
        .NUM_REQ(NUM_REQ), .A_WIDTH(A_WIDTH), .B_WIDTH(B_WIDTH), .P_WIDTH(P_WIDTH), .ID_W(ID_W)
    ) bus ();

    always_comb begin
        bus.req_a = '0;
        bus.req_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.req_a[i*A_WIDTH +: A_WIDTH] = a_r[i];
            bus.req_b[i*B_WIDTH +: B_WIDTH] = b_r[i];
        end
    end

    decompose_mul_share_arb #(
        .NUM_REQ(NUM_REQ), .A_WIDTH(A_WIDTH), .B_WIDTH(B_WIDTH), .P_WIDTH(P_WIDTH),
        .MUL_LATENCY(MUL_LATENCY), .ID_W(ID_W)
    ) dut (
        .clk(clk), .reset(reset), .ce(ce), .bus(bus),
        .mul_din0(mul_din0), .mul_din1(mul_din1), .mul_ce(mul_ce),
        .mul_dout(mul_dout), .busy(busy)
    );

    // External pipelined multiplier: not reset, frozen while ce is low.
    logic [P_WIDTH-1:0] mstage [MUL_LATENCY];
    always @(posedge clk) begin
        if (mul_ce) begin
            mstage[0] <= P_WIDTH'(64'(mul_din0) * 64'(mul_din1));
            for (int i = 1; i < MUL_LATENCY; i++) mstage[i] <= mstage[i-1];
        end
    end
    assign mul_dout = mstage[MUL_LATENCY-1];

    function automatic logic [P_WIDTH-1:0] prod(input logic [A_WIDTH-1:0] a,
                                                input logic [B_WIDTH-1:0] b);
        logic [63:0] p;
        p = 64'(a) * 64'(b);
        return p[P_WIDTH-1:0];
    endfunction

    function automatic logic [A_WIDTH-1:0] rand_a();
        return A_WIDTH'($urandom());
    endfunction

    function automatic logic [B_WIDTH-1:0] rand_b();
        return B_WIDTH'({$urandom(), $urandom()});
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        ce = 1'b1;
        bus.req_valid = '0;
        bus.res_ready = 1'b1;
        tick();
        tick();
        #2 reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        ce = 1'b1;
        bus.res_ready = 1'b1;
        bus.req_valid = '1;
        for (int i = 0; i < NUM_REQ; i++) begin a_r[i] = rand_a(); b_r[i] = rand_b(); end
        tick();
        checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL rst_req_ready got %b want 0000", bus.req_ready); end
        checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL rst_res_valid got %b want 0", bus.res_valid); end
        checks++; if (bus.res_id !== 2'd0) begin errors++; $display("FAIL rst_res_id got %0d want 0", bus.res_id); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
        #2 reset = 1'b0;
        @(negedge clk);
        checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL rst_first_grant got %b want 0001", bus.req_ready); end
        tick();
        bus.req_valid = '0;
        checks++; if (bus.res_id !== 2'd0 || bus.res_valid !== 1'b1) begin errors++; $display("FAIL rst_first_result got v=%b id=%0d want v=1 id=0", bus.res_valid, bus.res_id); end
        tick();
    endtask

    task automatic test_single();
        do_reset();
        a_r[0] = 31'd3; b_r[0] = 33'd5;
        bus.req_valid = 4'b0001;
        @(negedge clk);
        checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL single_ready got %b want 0001", bus.req_ready); end
        checks++; if (mul_din0 !== 31'd3 || mul_din1 !== 33'd5) begin errors++; $display("FAIL single_operands got %0d,%0d want 3,5", mul_din0, mul_din1); end
        checks++; if (mul_ce !== 1'b1) begin errors++; $display("FAIL single_mul_ce got %b want 1", mul_ce); end
        tick();
        bus.req_valid = '0;
        checks++; if (bus.res_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b want 1", bus.res_valid); end
        checks++; if (bus.res_data !== 44'd15) begin errors++; $display("FAIL single_data got %0d want 15", bus.res_data); end
        checks++; if (bus.res_id !== 2'd0) begin errors++; $display("FAIL single_id got %0d want 0", bus.res_id); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got %b want 1", busy); end
        tick();
        checks++; if (bus.res_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL single_drain got v=%b busy=%b want 0,0", bus.res_valid, busy); end
    endtask

    task automatic test_round_robin();
        logic [A_WIDTH-1:0] ea;
        logic [B_WIDTH-1:0] eb;
        logic [NUM_REQ-1:0] exp_rr;
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) begin a_r[i] = rand_a(); b_r[i] = rand_b(); end
        bus.req_valid = '1;
        for (int k = 0; k < 8; k++) begin
            exp_rr = '0;
            exp_rr[k % NUM_REQ] = 1'b1;
            @(negedge clk);
            checks++; if (bus.req_ready !== exp_rr) begin errors++; $display("FAIL rr_grant[%0d] got %b want %b", k, bus.req_ready, exp_rr); end
            ea = a_r[k % NUM_REQ];
            eb = b_r[k % NUM_REQ];
            tick();
            checks++; if (bus.res_valid !== 1'b1 || bus.res_id !== ID_W'(k % NUM_REQ)) begin errors++; $display("FAIL rr_result[%0d] got v=%b id=%0d want v=1 id=%0d", k, bus.res_valid, bus.res_id, k % NUM_REQ); end
            checks++; if (bus.res_data !== prod(ea, eb)) begin errors++; $display("FAIL rr_data[%0d] got %h want %h", k, bus.res_data, prod(ea, eb)); end
            a_r[k % NUM_REQ] = rand_a();
            b_r[k % NUM_REQ] = rand_b();
        end
        bus.req_valid = '0;
        tick();
        checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL rr_drain got %b want 0", bus.res_valid); end
    endtask

    task automatic test_stall();
        logic [P_WIDTH-1:0] p0, p1;
        do_reset();
        for (int i = 0; i < 2; i++) begin a_r[i] = rand_a(); b_r[i] = rand_b(); end
        p0 = prod(a_r[0], b_r[0]);
        p1 = prod(a_r[1], b_r[1]);
        bus.req_valid = 4'b0011;
        bus.res_ready = 1'b0;
        @(negedge clk);
        checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL stall_first_grant got %b want 0001", bus.req_ready); end
        tick();
        bus.req_valid[0] = 1'b0;
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            checks++; if (mul_ce !== 1'b0 || bus.req_ready !== 4'b0000) begin errors++; $display("FAIL stall_frozen[%0d] got ce=%b rdy=%b want 0,0000", s, mul_ce, bus.req_ready); end
            checks++; if (bus.res_valid !== 1'b1 || bus.res_id !== 2'd0 || bus.res_data !== p0) begin errors++; $display("FAIL stall_hold[%0d] got v=%b id=%0d d=%h want 1,0,%h", s, bus.res_valid, bus.res_id, bus.res_data, p0); end
            tick();
        end
        bus.res_ready = 1'b1;
        @(negedge clk);
        checks++; if (bus.req_ready !== 4'b0010 || mul_ce !== 1'b1) begin errors++; $display("FAIL stall_release got rdy=%b ce=%b want 0010,1", bus.req_ready, mul_ce); end
        tick();
        bus.req_valid = '0;
        checks++; if (bus.res_valid !== 1'b1 || bus.res_id !== 2'd1 || bus.res_data !== p1) begin errors++; $display("FAIL stall_next got v=%b id=%0d d=%h want 1,1,%h", bus.res_valid, bus.res_id, bus.res_data, p1); end
        tick();
        checks++; if (bus.res_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL stall_nodup got v=%b busy=%b want 0,0", bus.res_valid, busy); end
    endtask

    task automatic test_max_operands();
        do_reset();
        a_r[2] = '1;
        b_r[2] = '1;
        bus.req_valid = 4'b0100;
        @(negedge clk);
        checks++; if (bus.req_ready !== 4'b0100) begin errors++; $display("FAIL max_grant got %b want 0100", bus.req_ready); end
        tick();
        bus.req_valid = '0;
        checks++; if (bus.res_data !== 44'hFFD_8000_0001) begin errors++; $display("FAIL max_data got %h want %h", bus.res_data, 44'hFFD_8000_0001); end
        checks++; if (bus.res_data !== prod(a_r[2], b_r[2]) || bus.res_id !== 2'd2) begin errors++; $display("FAIL max_model got d=%h id=%0d want %h,2", bus.res_data, bus.res_id, prod(a_r[2], b_r[2])); end
        tick();
    endtask

    task automatic test_reset_mid_burst();
        logic [P_WIDTH-1:0] pn;
        do_reset();
        bus.res_ready = 1'b0;
        a_r[0] = 31'd7; b_r[0] = 33'd9;
        bus.req_valid = 4'b0001;
        tick();
        checks++; if (bus.res_valid !== 1'b1) begin errors++; $display("FAIL mid_inflight got %b want 1", bus.res_valid); end
        a_r[0] = rand_a(); b_r[0] = rand_b();
        a_r[2] = rand_a(); b_r[2] = rand_b();
        pn = prod(a_r[0], b_r[0]);
        bus.req_valid = 4'b0101;
        #2 reset = 1'b1;
        #1;
        checks++; if (bus.res_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mid_async_clear got v=%b busy=%b want 0,0", bus.res_valid, busy); end
        checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL mid_ready_in_reset got %b want 0000", bus.req_ready); end
        @(posedge clk);
        #3 reset = 1'b0;
        bus.res_ready = 1'b1;
        @(negedge clk);
        checks++; if (bus.req_ready !== 4'b0001 || bus.res_valid !== 1'b0) begin errors++; $display("FAIL mid_regrant got rdy=%b v=%b want 0001,0", bus.req_ready, bus.res_valid); end
        tick();
        bus.req_valid = '0;
        checks++; if (bus.res_valid !== 1'b1 || bus.res_id !== 2'd0 || bus.res_data !== pn) begin errors++; $display("FAIL mid_result got v=%b id=%0d d=%h want 1,0,%h", bus.res_valid, bus.res_id, bus.res_data, pn); end
        tick();
        checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL mid_nostale got %b want 0", bus.res_valid); end
    endtask

    typedef struct {
        logic [P_WIDTH-1:0] p;
        logic [ID_W-1:0]    id;
        int                 left;
    } inflight_t;

    task automatic test_random();
        inflight_t q[$];
        int last;
        int choice;
        bit found, exp_rv, adv, drain;
        logic [NUM_REQ-1:0] accepted, exp_rr;
        localparam int N_CYC = 10000;
        do_reset();
        last = NUM_REQ - 1;
        accepted = '0;
        for (int c = 0; c < N_CYC; c++) begin
            drain = (c >= N_CYC - 20);
            ce = drain ? 1'b1 : ($urandom_range(0, 3) != 0);
            bus.res_ready = drain ? 1'b1 : ($urandom_range(0, 2) != 0);
            for (int i = 0; i < NUM_REQ; i++) begin
                if (drain) begin
                    bus.req_valid[i] = 1'b0;
                end else if (accepted[i] || !bus.req_valid[i]) begin
                    bus.req_valid[i] = ($urandom_range(0, 1) == 1);
                    a_r[i] = rand_a();
                    b_r[i] = rand_b();
                end else if ($urandom_range(0, 7) == 0) begin
                    bus.req_valid[i] = 1'b0;
                end
            end
            @(negedge clk);
            exp_rv = (q.size() > 0) && (q[0].left == 0);
            adv = ce && (!exp_rv || bus.res_ready);
            found = 1'b0;
            choice = 0;
            for (int k = 1; k <= NUM_REQ; k++) begin
                if (!found && bus.req_valid[(last + k) % NUM_REQ]) begin
                    found = 1'b1;
                    choice = (last + k) % NUM_REQ;
                end
            end
            exp_rr = '0;
            if (adv && found) exp_rr[choice] = 1'b1;
            checks++; if (bus.res_valid !== exp_rv) begin errors++; $display("FAIL rnd_valid c=%0d got %b want %b", c, bus.res_valid, exp_rv); end
            checks++; if (busy !== (q.size() > 0)) begin errors++; $display("FAIL rnd_busy c=%0d got %b want %b", c, busy, q.size() > 0); end
            checks++; if (mul_ce !== adv) begin errors++; $display("FAIL rnd_mul_ce c=%0d got %b want %b", c, mul_ce, adv); end
            checks++; if (bus.req_ready !== exp_rr) begin errors++; $display("FAIL rnd_grant c=%0d got %b want %b", c, bus.req_ready, exp_rr); end
            if (exp_rv) begin
                checks++; if (bus.res_id !== q[0].id || bus.res_data !== q[0].p) begin errors++; $display("FAIL rnd_result c=%0d got id=%0d d=%h want id=%0d d=%h", c, bus.res_id, bus.res_data, q[0].id, q[0].p); end
            end
            accepted = '0;
            if (adv) begin
                if (exp_rv) void'(q.pop_front());
                foreach (q[j]) q[j].left--;
                if (found) begin
                    q.push_back('{p: prod(a_r[choice], b_r[choice]), id: ID_W'(choice), left: MUL_LATENCY - 1});
                    last = choice;
                    accepted[choice] = 1'b1;
                end
            end
            tick();
        end
        checks++; if (busy !== 1'b0 || bus.res_valid !== 1'b0) begin errors++; $display("FAIL rnd_final_idle got busy=%b v=%b want 0,0", busy, bus.res_valid); end
    endtask

    initial begin
        reset = 1'b1;
        ce = 1'b0;
        bus.req_valid = '0;
        bus.res_ready = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin a_r[i] = '0; b_r[i] = '0; end
        #3;
        test_reset();
        test_single();
        test_round_robin();
        test_stall();
        test_max_operands();
        test_reset_mid_burst();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
